noaa_result_fifo: RTL and testbench

Downstream stage of the NOAA averaging/std-dev engine. Captures each 12-bit AVG_SD result on DONE and tags it as average (0) or std-dev (1) by delaying MODE to match the engine's pipeline. Buffers results in a small FIFO drained by a valid/ready consumer (logger/UART framer). Also raises a sticky alarm when a std-dev result exceeds a limit, and counts results dropped on overflow.

---
 rtl/noaa_pkg.sv | 23 ++
 rtl/noaa_sync_fifo.sv | 64 ++++++
 rtl/noaa_result_fifo.sv | 86 ++++++++
 tb/tb_noaa_result_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/noaa_pkg.sv
// Shared definitions for the NOAA averaging/std-dev result path.
package noaa_pkg;
    localparam int RESULT_W = 12;
    localparam int ENTRY_W  = RESULT_W + 1;

    localparam logic MODE_AVG = 1'b0;
    localparam logic MODE_SD  = 1'b1;

    // Engine latency from MODE sample to the matching DONE strobe.
    localparam int                  TAG_DELAY_DEF = 3;
    localparam logic [RESULT_W-1:0] SD_LIMIT_DEF  = 12'd64;

    typedef struct packed {
        logic                is_sd;
        logic [RESULT_W-1:0] data;
    } result_entry_t;

    function automatic logic sd_over_limit(input logic                is_sd,
                                           input logic [RESULT_W-1:0] value,
                                           input logic [RESULT_W-1:0] limit);
        return (is_sd == MODE_SD) && (value > limit);
    endfunction
endpackage

// File: rtl/noaa_sync_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered head outputs.
module noaa_sync_fifo
    import noaa_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  W     = ENTRY_W,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic [AW:0]   count
);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         rd_valid_q, rd_valid_d;
    logic [W-1:0] rd_data_q, rd_data_d;
    logic         pop, wr_en;

    assign count    = wptr_q - rptr_q;
    assign full     = (count == (AW+1)'(DEPTH));
    assign pop      = rd_valid_q & rd_ready;
    assign wr_en    = push & (~full | pop);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

    // The head register is loaded from the next read address; when that slot is
    // the one being written this edge, take the incoming word instead.
    always_comb begin
        wptr_d     = wptr_q + {{AW{1'b0}}, wr_en};
        rptr_d     = rptr_q + {{AW{1'b0}}, pop};
        rd_valid_d = (wptr_d != rptr_d);
        if (wr_en && (wptr_q == rptr_d)) begin
            rd_data_d = wdata;
        end else begin
            rd_data_d = mem[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q[AW-1:0]] <= wdata;
        end
    end
endmodule

// File: rtl/noaa_result_fifo.sv
// Tags NOAA engine results as average/std-dev, buffers them, and tracks drops and std-dev alarms.
module noaa_result_fifo
    import noaa_pkg::*;
#(
    parameter int                  DEPTH     = 8,
    parameter int                  TAG_DELAY = TAG_DELAY_DEF,
    parameter logic [RESULT_W-1:0] SD_LIMIT  = SD_LIMIT_DEF,
    localparam int                 CW        = $clog2(DEPTH) + 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                MODE,
    input  logic                DONE,
    input  logic [RESULT_W-1:0] AVG_SD,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [RESULT_W-1:0] OUT_DATA,
    output logic                OUT_IS_SD,
    output logic [CW-1:0]       COUNT,
    output logic                OVERFLOW,
    output logic [7:0]          DROP_CNT,
    output logic                SD_ALARM
);
    logic [TAG_DELAY-1:0] tag_q, tag_d;
    logic                 tag, full, pop_fire, drop;
    logic                 overflow_q, overflow_d, sd_alarm_q, sd_alarm_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    result_entry_t        wentry, rentry;

    // MODE delay line; the oldest stage lines up with the DONE for that sample.
    for (genvar gi = 0; gi < TAG_DELAY; gi++) begin : g_tag
        if (gi == 0) begin : g_first
            assign tag_d[gi] = MODE;
        end else begin : g_rest
            assign tag_d[gi] = tag_q[gi-1];
        end
    end
    assign tag = tag_q[TAG_DELAY-1];

    assign pop_fire = OUT_VALID & OUT_READY;
    assign drop     = DONE & full & ~pop_fire;
    assign wentry   = '{is_sd: tag, data: AVG_SD};

    noaa_sync_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
        .clk      (CLK),
        .srst     (RESET),
        .push     (DONE),
        .wdata    (wentry),
        .rd_ready (OUT_READY),
        .rd_valid (OUT_VALID),
        .rd_data  (rentry),
        .full     (full),
        .count    (COUNT)
    );

    assign OUT_DATA  = rentry.data;
    assign OUT_IS_SD = rentry.is_sd;

    // Alarm looks at every tagged result, including ones that are dropped.
    always_comb begin
        overflow_d = overflow_q | drop;
        sd_alarm_d = sd_alarm_q | (DONE & sd_over_limit(tag, AVG_SD, SD_LIMIT));
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tag_q      <= '0;
            overflow_q <= 1'b0;
            sd_alarm_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            tag_q      <= tag_d;
            overflow_q <= overflow_d;
            sd_alarm_q <= sd_alarm_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign OVERFLOW = overflow_q;
    assign DROP_CNT = drop_cnt_q;
    assign SD_ALARM = sd_alarm_q;
endmodule

// File: tb/tb_noaa_result_fifo.sv
// Randomised and directed bench for noaa_result_fifo against a queue-based reference model.
module tb_noaa_result_fifo;
    localparam int          DEPTH = 8;
    localparam int          TD    = 3;
    localparam logic [11:0] LIM   = 12'd64;

    logic        clk = 1'b0;
    logic        rst, mode, done, ready;
    logic [11:0] avg_sd;
    logic        out_valid, out_is_sd, overflow, sd_alarm;
    logic [11:0] out_data;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    noaa_result_fifo #(.DEPTH(DEPTH), .TAG_DELAY(TD), .SD_LIMIT(LIM)) dut (
        .CLK(clk), .RESET(rst), .MODE(mode), .DONE(done), .AVG_SD(avg_sd),
        .OUT_VALID(out_valid), .OUT_READY(ready), .OUT_DATA(out_data),
        .OUT_IS_SD(out_is_sd), .COUNT(count), .OVERFLOW(overflow),
        .DROP_CNT(drop_cnt), .SD_ALARM(sd_alarm)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    int q_data[$];
    int q_tag[$];
    int mode_hist[$];
    int m_over, m_drop, m_alarm;
    bit m_rst_zero;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_tag.delete();
        mode_hist.delete();
        for (int i = 0; i < TD; i++) mode_hist.push_back(0);
        m_over = 0;
        m_drop = 0;
        m_alarm = 0;
        m_rst_zero = 1;
    endtask

    // Apply one clock edge's worth of behaviour to the model.
    task automatic model_edge();
        int tag, sz0;
        bit pop;
        if (rst) begin
            model_reset();
            return;
        end
        m_rst_zero = 0;
        tag = mode_hist.pop_front();
        mode_hist.push_back(int'(mode));
        sz0 = q_data.size();
        pop = (sz0 > 0) && ready;
        if (pop) begin
            $display("pop data=0x%03h sd=%0d", q_data[0], q_tag[0]);
            void'(q_data.pop_front());
            void'(q_tag.pop_front());
        end
        if (done) begin
            if (tag == 1 && int'(avg_sd) > int'(LIM)) m_alarm = 1;
            if (sz0 == DEPTH && !pop) begin
                m_over = 1;
                if (m_drop < 255) m_drop++;
            end else begin
                q_data.push_back(int'(avg_sd));
                q_tag.push_back(tag);
            end
        end
    endtask

    task automatic compare_all();
        check("valid", out_valid, (q_data.size() != 0));
        check("count", count, q_data.size());
        check("overflow", overflow, m_over);
        check("drop_cnt", drop_cnt, m_drop);
        check("sd_alarm", sd_alarm, m_alarm);
        if (q_data.size() != 0) begin
            check("out_data", out_data, q_data[0]);
            check("out_is_sd", out_is_sd, q_tag[0]);
        end
        if (m_rst_zero) begin
            check("rst_data", out_data, 0);
            check("rst_is_sd", out_is_sd, 0);
        end
    endtask

    task automatic cycle(input logic m, input logic d, input logic [11:0] v,
                         input logic r, input logic rs);
        mode = m; done = d; avg_sd = v; ready = r; rst = rs;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        mode = 0; done = 0; avg_sd = 0; ready = 0; rst = 1;
        model_reset();
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);

        // Basic FWFT ordering and hold while not ready
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 12'h100, 0, 0);
        cycle(0, 1, 12'h104, 0, 0);
        check("t1_head", out_data, 12'h100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        check("t1_empty", count, 0);

        // Tag alignment: one MODE pulse, DONE two to four edges later
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 1, 12'h011, 0, 0);
        cycle(0, 1, 12'h012, 0, 0);
        cycle(0, 1, 12'h013, 0, 0);
        check("t2_first_tag", out_is_sd, 0);
        cycle(0, 0, 0, 1, 0);
        check("t2_second_tag", out_is_sd, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);

        // Overflow: ten pushes into an eight-deep FIFO
        for (int i = 1; i <= 10; i++) cycle(0, 1, 12'(i), 0, 0);
        check("t3_count", count, DEPTH);
        check("t3_drop", drop_cnt, 2);
        check("t3_over", overflow, 1);

        // Full with simultaneous push and pop
        cycle(0, 1, 12'h0AA, 1, 0);
        check("t4_count", count, DEPTH);
        check("t4_drop", drop_cnt, 2);
        for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 1, 0);

        // Alarm threshold
        cycle(0, 0, 0, 1, 1);
        cycle(0, 1, 12'h7FF, 1, 0);
        for (int i = 0; i < TD; i++) cycle(1, 0, 0, 1, 0);
        check("t5_avg_no_alarm", sd_alarm, 0);
        cycle(1, 1, 12'h040, 1, 0);
        check("t5_at_limit", sd_alarm, 0);
        cycle(1, 1, 12'h041, 1, 0);
        check("t5_over_limit", sd_alarm, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

        // Reset mid-operation discards entries and sticky flags
        for (int i = 0; i < 10; i++) cycle(1, 1, 12'h300 + 12'(i), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        check("t6_pre_count", count, 5);
        cycle(0, 1, 12'h555, 0, 1);
        check("t6_valid", out_valid, 0);
        check("t6_count", count, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

        // Drop counter saturation
        for (int i = 0; i < 270; i++) cycle(0, 1, 12'(i), 0, 0);
        check("sat_drop", drop_cnt, 255);
        cycle(0, 0, 0, 1, 1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 55),
                  12'($urandom_range(0, 3) == 0 ? $urandom_range(0, 4095) : $urandom_range(60, 70)),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
